uart_cmd_ctrl: RTL
==================

Name: uart_cmd_ctrl

Overview:
- Command controller between the RX FIFO, the TX FIFO and a report generator in the UART dual-watch design.
- Pops received bytes from the RX FIFO and decodes single-character commands into one-cycle control pulses for the watch core.
- Optionally echoes each byte back through the TX FIFO.
- Arbitrates TX FIFO write access between the echo path and a packetised report stream.

Parameters:
- ECHO_EN, 1, 1 = echo every received byte to TX; 0 = no echo
- CMD_RUN, 8'h52, 'R': run/stop toggle
- CMD_CLEAR, 8'h43, 'C': clear
- CMD_MODE, 8'h4D, 'M': mode switch
- CMD_STAT, 8'h53, 'S': request status report

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_rdata  in  8  RX FIFO head data; valid while rx_empty=0 (show-ahead)
- rx_empty  in  1  RX FIFO empty
- rx_pop  out  1  RX FIFO pop strobe
- tx_wdata  out  8  TX FIFO write data
- tx_push  out  1  TX FIFO push strobe
- tx_full  in  1  TX FIFO full
- rpt_valid  in  1  report byte valid
- rpt_data  in  8  report byte
- rpt_last  in  1  marks the final byte of a report packet
- rpt_ready  out  1  report byte accepted this cycle
- cmd_run  out  1  one-cycle pulse
- cmd_clear  out  1  one-cycle pulse
- cmd_mode  out  1  one-cycle pulse
- rpt_start  out  1  one-cycle pulse; asks the generator for a report
- err_cnt  out  8  count of unrecognised bytes, saturating at 255

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on any edge with rst=1 the block goes to IDLE.
- Reset values:
  - state=IDLE, byte_q=0, last_grant=RPT (so RX wins the first tie), err_cnt=0.
  - All pulses, rx_pop, tx_push and rpt_ready = 0.
- Reset mid-operation: a byte already popped is discarded and an in-flight report packet is abandoned. The generator must be reset by the same rst.
- States: IDLE, DECODE, ECHO, RPT.
- IDLE:
  - rx_req = !rx_empty; rpt_req = rpt_valid.
  - Only rx_req: rx_pop=1 (combinational), byte_q<=rx_rdata, next DECODE, last_grant<=RX.
  - Only rpt_req: next RPT, last_grant<=RPT. No byte is transferred in this cycle.
  - Both: round-robin. Grant goes to the side not in last_grant.
  - Neither: stay in IDLE.
- DECODE (one cycle):
  - Compare uppercase(byte_q), i.e. byte_q & 8'hDF when byte_q is in 8'h61..8'h7A, else byte_q.
  - Compare against CMD_RUN / CMD_CLEAR / CMD_MODE / CMD_STAT. On a match, the corresponding output is registered high for exactly one cycle (the cycle after DECODE).
  - No match: err_cnt increments, saturating at 255.
  - Next state is ECHO if ECHO_EN=1, else IDLE.
- ECHO:
  - tx_wdata=byte_q.
  - tx_push=!tx_full (combinational). When tx_push=1, next state is IDLE; otherwise wait in ECHO.
  - No RX pop occurs while waiting, so RX back-pressure reaches the RX FIFO.
- RPT:
  - rpt_ready=!tx_full. tx_push=rpt_valid&&!tx_full. tx_wdata=rpt_data.
  - On a transfer with rpt_last=1, next state is IDLE.
  - A packet is never interleaved with echo bytes. RX bytes wait until the packet ends.
  - rpt_valid low mid-packet: stay in RPT.
- tx_wdata = 0 whenever tx_push=0.
- Latency, per byte, from rx_empty falling with the block in IDLE:
  - cycle 0: pop.
  - cycle 1: DECODE.
  - cycle 2: command pulse visible; echo push if not full.
  - cycle 3: IDLE again.
  - Steady-state throughput: 1 byte per 3 cycles (2 when ECHO_EN=0).
- rx_pop is never asserted while rx_empty=1. tx_push is never asserted while tx_full=1.

Test Plan:
- Reset, then push 'R' (8'h52) into an empty RX FIFO. Required:
  - rx_pop high 1 cycle.
  - cmd_run high exactly 1 cycle, 2 cycles after the pop.
  - tx_push with tx_wdata=8'h52 in the same cycle.
  - Back to IDLE.
- Bytes 'c','m','s','x' back-to-back. Required:
  - cmd_clear, cmd_mode, rpt_start each pulse once, in order.
  - err_cnt=1.
  - Echo stream is 63 6D 73 78.
  - Pops are spaced 3 cycles apart.
- Hold tx_full=1 for 10 cycles after 'C' is popped. Required:
  - cmd_clear still pulses.
  - No tx_push while full.
  - No further rx_pop while full.
  - Echo 8'h43 pushed on the first cycle tx_full=0.
- 3-byte report packet (AA BB CC, rpt_last on CC) while RX holds 'R':
  - Starting with last_grant=RPT, RX is granted first: echo 52 is pushed, then AA BB CC contiguously.
  - 'R' arriving mid-packet is not popped until after CC.
- Simultaneous requests repeated 4 times. Required: grants alternate RX, RPT, RX, RPT.
- 260 unknown bytes (8'h00). Required: err_cnt saturates at 8'hFF.
- Assert rst during ECHO with tx_full=1. Required:
  - All outputs 0 on the next cycle.
  - No echo is produced.
  - err_cnt=0.
  - The next RX byte is processed normally.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: pops RX bytes, decodes single-char commands,
// echoes bytes and arbitrates TX FIFO writes against a report packet stream.
module uart_cmd_ctrl #(
    parameter bit         ECHO_EN   = 1'b1,
    parameter logic [7:0] CMD_RUN   = 8'h52,
    parameter logic [7:0] CMD_CLEAR = 8'h43,
    parameter logic [7:0] CMD_MODE  = 8'h4D,
    parameter logic [7:0] CMD_STAT  = 8'h53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_rdata,
    input  logic       rx_empty,
    output logic       rx_pop,
    output logic [7:0] tx_wdata,
    output logic       tx_push,
    input  logic       tx_full,
    input  logic       rpt_valid,
    input  logic [7:0] rpt_data,
    input  logic       rpt_last,
    output logic       rpt_ready,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic       rpt_start,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        ECHO,
        RPT
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] byte_q;
    logic [7:0] byte_up;
    logic       last_rpt;
    logic       grant_rx;
    logic       grant_rpt;
    logic       hit_run;
    logic       hit_clear;
    logic       hit_mode;
    logic       hit_stat;

    always_comb begin
        byte_up = byte_q;
        if (byte_q >= 8'h61 && byte_q <= 8'h7A) begin
            byte_up = byte_q & 8'hDF;
        end
    end

    assign hit_run   = (byte_up == CMD_RUN);
    assign hit_clear = (byte_up == CMD_CLEAR);
    assign hit_mode  = (byte_up == CMD_MODE);
    assign hit_stat  = (byte_up == CMD_STAT);

    // Strobes are gated by rst so nothing leaks out while the state
    // register is still waiting for the reset edge.
    always_comb begin
        state_nx  = state;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        tx_wdata  = 8'h00;
        rpt_ready = 1'b0;
        grant_rx  = 1'b0;
        grant_rpt = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    grant_rx  = !rx_empty && (!rpt_valid || last_rpt);
                    grant_rpt = rpt_valid && (rx_empty || !last_rpt);
                    rx_pop    = grant_rx;
                    if (grant_rx) begin
                        state_nx = DECODE;
                    end else if (grant_rpt) begin
                        state_nx = RPT;
                    end
                end
                DECODE: begin
                    state_nx = ECHO_EN ? ECHO : IDLE;
                end
                ECHO: begin
                    tx_push = !tx_full;
                    if (!tx_full) begin
                        tx_wdata = byte_q;
                        state_nx = IDLE;
                    end
                end
                RPT: begin
                    rpt_ready = !tx_full;
                    tx_push   = rpt_valid && !tx_full;
                    if (rpt_valid && !tx_full) begin
                        tx_wdata = rpt_data;
                        if (rpt_last) begin
                            state_nx = IDLE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_q    <= 8'h00;
            last_rpt  <= 1'b1;
            err_cnt   <= 8'h00;
            cmd_run   <= 1'b0;
            cmd_clear <= 1'b0;
            cmd_mode  <= 1'b0;
            rpt_start <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_run   <= 1'b0;
            cmd_clear <= 1'b0;
            cmd_mode  <= 1'b0;
            rpt_start <= 1'b0;
            if (grant_rx) begin
                byte_q   <= rx_rdata;
                last_rpt <= 1'b0;
            end else if (grant_rpt) begin
                last_rpt <= 1'b1;
            end
            if (state == DECODE) begin
                cmd_run   <= hit_run;
                cmd_clear <= hit_clear;
                cmd_mode  <= hit_mode;
                rpt_start <= hit_stat;
                if (!(hit_run || hit_clear || hit_mode || hit_stat)
                    && err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
